// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_pkg
// Purpose : Shared definitions for the program-counter sequencer: FSM state
//           encoding and default reset/exception vectors.
// Revision: 1.0 - initial release
// ============================================================================
package pc_pkg;

  // Sequencer states: RUN (not stalled), HOLD (stalled, nothing buffered),
  // HOLD_PEND (stalled, a redirect target is buffered).
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    HOLD      = 2'b01,
    HOLD_PEND = 2'b10
  } pc_state_t;

  localparam logic [31:0] c_def_reset_vector = 32'h0000_0000;
  localparam logic [31:0] c_def_exc_vector   = 32'h0000_0004;

endpackage
`default_nettype wire

// File: rtl/pc_redirect_hist.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_hist
// Purpose : Ring buffer of PC values captured at each applied redirect or
//           exception load. Index 0 on the read port is the newest entry.
// Ports   : i_clk      - clock, rising edge
//           i_rst_n    - asynchronous active-low reset (clears all entries)
//           i_we       - capture i_data into the next slot
//           i_data     - PC value to record
//           i_idx      - read index, 0 = newest
//           o_data     - combinational read data
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_hist #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned HIST_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_we,
  input  logic [ADDR_W-1:0]             i_data,
  input  logic [$clog2(HIST_DEPTH)-1:0] i_idx,
  output logic [ADDR_W-1:0]             o_data
);

  localparam int unsigned c_iw = $clog2(HIST_DEPTH);

  logic [ADDR_W-1:0] r_mem [HIST_DEPTH];
  logic [c_iw-1:0]   r_wptr;
  logic [c_iw-1:0]   w_rd_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      for (int i = 0; i < int'(HIST_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[r_wptr] <= i_data;
      r_wptr        <= r_wptr + c_iw'(1);
    end
  end

  // Depth is a power of two, so pointer arithmetic wraps naturally.
  assign w_rd_ptr = r_wptr - c_iw'(1) - i_idx;
  assign o_data   = r_mem[w_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Purpose : Fetch-stage program counter with stall-safe redirect buffering,
//           exception vectoring and misaligned-target flagging.
//           Optional redirect history enabled by macro PC_REDIRECT_HIST_EN.
// Ports   : CLK          - clock, rising edge
//           Reset_n      - asynchronous active-low reset
//           Busy         - stall; PC holds while high
//           PCSrc        - redirect request, target on Result
//           Result       - redirect target
//           Exception    - exception request, highest priority
//           PC           - current fetch address (registered)
//           PC_Plus_Step - PC + STEP, combinational, wraps
//           Pend         - a redirect is buffered (registered)
//           Misalign     - one-cycle pulse after a misaligned target load
//           Hist_Idx     - history read index (0 = newest)
//           Hist_Data    - history entry, 0 when history is not built
// Revision: 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(c_def_reset_vector),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(c_def_exc_vector),
  parameter int unsigned       STEP         = 4,
  parameter int unsigned       HIST_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          Reset_n,
  input  logic                          Busy,
  input  logic                          PCSrc,
  input  logic [ADDR_W-1:0]             Result,
  input  logic                          Exception,
  output logic [ADDR_W-1:0]             PC,
  output logic [ADDR_W-1:0]             PC_Plus_Step,
  output logic                          Pend,
  output logic                          Misalign,
  input  logic [$clog2(HIST_DEPTH)-1:0] Hist_Idx,
  output logic [ADDR_W-1:0]             Hist_Data
);

  localparam logic [ADDR_W-1:0] c_step       = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] c_align_mask = ADDR_W'(STEP - 1);

  pc_state_t         r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              r_pend;
  logic              r_misalign;

  logic [ADDR_W-1:0] w_pc_plus;
  logic              w_res_mis;
  logic              w_pend_mis;

  assign w_pc_plus  = r_pc + c_step;
  assign w_res_mis  = (Result & c_align_mask) != '0;
  assign w_pend_mis = (r_pend_tgt & c_align_mask) != '0;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_VECTOR;
      r_pend_tgt <= '0;
      r_pend     <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (Exception) begin
        // Exception beats everything and drops any buffered redirect.
        r_pc    <= EXC_VECTOR;
        r_pend  <= 1'b0;
        r_state <= Busy ? HOLD : RUN;
      end else begin
        case (r_state)
          HOLD_PEND: begin
            if (Busy) begin
              if (PCSrc) r_pend_tgt <= Result;   // latest redirect wins
            end else begin
              // Buffered redirect is applied; a concurrent PCSrc is dropped.
              r_pc       <= r_pend_tgt;
              r_pend     <= 1'b0;
              r_misalign <= w_pend_mis;
              r_state    <= RUN;
            end
          end
          default: begin // RUN and HOLD behave identically
            if (Busy) begin
              if (PCSrc) begin
                r_pend_tgt <= Result;
                r_pend     <= 1'b1;
                r_state    <= HOLD_PEND;
              end else begin
                r_state    <= HOLD;
              end
            end else begin
              r_state <= RUN;
              if (PCSrc) begin
                r_pc       <= Result;
                r_misalign <= w_res_mis;
              end else begin
                r_pc       <= w_pc_plus;
              end
            end
          end
        endcase
      end
    end
  end

  assign PC           = r_pc;
  assign PC_Plus_Step = w_pc_plus;
  assign Pend         = r_pend;
  assign Misalign     = r_misalign;

`ifdef PC_REDIRECT_HIST_EN
  // A non-sequential PC load happens on an exception, on applying the
  // buffered target, or on a direct redirect while not stalled.
  logic w_hist_we;
  assign w_hist_we = Exception |
                     (!Busy && ((r_state == HOLD_PEND) || PCSrc));

  pc_redirect_hist #(
    .ADDR_W     (ADDR_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .i_clk   (CLK),
    .i_rst_n (Reset_n),
    .i_we    (w_hist_we),
    .i_data  (r_pc),
    .i_idx   (Hist_Idx),
    .o_data  (Hist_Data)
  );
`else
  logic w_unused_hist_idx;
  assign w_unused_hist_idx = ^Hist_Idx;
  assign Hist_Data         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Purpose : Self-checking bench for pc_sequencer: directed vector table,
//           hand sequences for async reset / wrap / history, and randomized
//           traffic against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         Reset_n;
  logic         Busy, PCSrc, Exception;
  logic [W-1:0] Result;
  logic [1:0]   Hist_Idx;
  logic [W-1:0] PC, PC_Plus_Step, Hist_Data;
  logic         Pend, Misalign;
  logic [7:0]   PC8, PC8_Plus, Hist8;
  logic         Pend8, Mis8;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .ADDR_W(W), .RESET_VECTOR(16'h0020), .EXC_VECTOR(16'h0004),
    .STEP(4), .HIST_DEPTH(4)
  ) u_dut (
    .CLK(CLK), .Reset_n(Reset_n), .Busy(Busy), .PCSrc(PCSrc),
    .Result(Result), .Exception(Exception), .PC(PC),
    .PC_Plus_Step(PC_Plus_Step), .Pend(Pend), .Misalign(Misalign),
    .Hist_Idx(Hist_Idx), .Hist_Data(Hist_Data)
  );

  // Narrow instance used for the modulo-wrap check.
  pc_sequencer #(.ADDR_W(8), .STEP(4), .HIST_DEPTH(4)) u_dut8 (
    .CLK(CLK), .Reset_n(Reset_n), .Busy(Busy), .PCSrc(PCSrc),
    .Result(Result[7:0]), .Exception(Exception), .PC(PC8),
    .PC_Plus_Step(PC8_Plus), .Pend(Pend8), .Misalign(Mis8),
    .Hist_Idx(Hist_Idx), .Hist_Data(Hist8)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_pc, m_tgt;
  logic         m_pend, m_mis;
  logic [W-1:0] m_hist[$];   // newest first

  task automatic m_reset();
    m_pc = 16'h0020; m_tgt = '0; m_pend = 1'b0; m_mis = 1'b0;
    m_hist = '{16'h0, 16'h0, 16'h0, 16'h0};
  endtask

  task automatic m_load(input logic [W-1:0] t, input logic flag_mis);
    m_hist.push_front(m_pc);
    void'(m_hist.pop_back());
    m_pc  = t;
    m_mis = flag_mis && (t % 4 != 0);
  endtask

  task automatic m_step(input logic b, s, e, input logic [W-1:0] r);
    m_mis = 1'b0;
    if (e) begin
      m_load(16'h0004, 1'b0);
      m_pend = 1'b0;
    end else if (b) begin
      if (s) begin m_pend = 1'b1; m_tgt = r; end
    end else if (m_pend) begin
      m_load(m_tgt, 1'b1);
      m_pend = 1'b0;
    end else if (s) begin
      m_load(r, 1'b1);
    end else begin
      m_pc = W'((32'(m_pc) + 4) % 65536);
    end
  endtask

  function automatic logic [W-1:0] m_hist_rd(input int idx);
`ifdef PC_REDIRECT_HIST_EN
    return m_hist[idx];
`else
    return '0;
`endif
  endfunction

  task automatic drive(input logic b, s, e, input logic [W-1:0] r);
    Busy = b; PCSrc = s; Exception = e; Result = r;
    @(posedge CLK); #1;
    m_step(b, s, e, r);
  endtask

  task automatic do_reset();
    @(negedge CLK); Reset_n = 1'b0;
    Busy = 0; PCSrc = 0; Exception = 0; Result = '0;
    @(negedge CLK); Reset_n = 1'b1;
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic b, s, e;
    logic [W-1:0] r;
    logic [W-1:0] pc;
    logic pend, mis;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{0,0,0,16'h0000, 16'h0024,0,0};
    tbl[1]  = '{0,1,0,16'h0010, 16'h0010,0,0};
    tbl[2]  = '{1,1,0,16'h0040, 16'h0010,1,0};
    tbl[3]  = '{1,1,0,16'h0080, 16'h0010,1,0};
    tbl[4]  = '{1,0,0,16'h0000, 16'h0010,1,0};
    tbl[5]  = '{0,1,0,16'h0200, 16'h0080,0,0};
    tbl[6]  = '{0,0,0,16'h0000, 16'h0084,0,0};
    tbl[7]  = '{1,1,0,16'h0300, 16'h0084,1,0};
    tbl[8]  = '{1,0,1,16'h0000, 16'h0004,0,0};
    tbl[9]  = '{1,0,0,16'h0000, 16'h0004,0,0};
    tbl[10] = '{0,0,0,16'h0000, 16'h0008,0,0};
    tbl[11] = '{0,1,0,16'h0102, 16'h0102,0,1};
    tbl[12] = '{0,0,0,16'h0000, 16'h0106,0,0};
    tbl[13] = '{1,1,0,16'h0203, 16'h0106,1,0};
    tbl[14] = '{0,0,0,16'h0000, 16'h0203,0,1};
    tbl[15] = '{0,0,0,16'h0000, 16'h0207,0,0};
    tbl[16] = '{0,1,1,16'h0401, 16'h0004,0,0};
    tbl[17] = '{0,0,0,16'h0000, 16'h0008,0,0};
  end

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0; Busy = 0; PCSrc = 0; Exception = 0; Result = '0; Hist_Idx = '0;
    m_reset();
    #12;
    chk("reset_pc",   32'(PC), 32'h0020);
    chk("reset_pend", 32'(Pend), 0);
    chk("reset_mis",  32'(Misalign), 0);
    chk("reset_plus", 32'(PC_Plus_Step), 32'h0024);
    chk("reset_pc8",  32'(PC8), 0);
    @(negedge CLK); Reset_n = 1'b1;

    // Async reset while stalled with a buffered redirect.
    drive(0, 1, 0, 16'h0030);
    drive(1, 1, 0, 16'h0055);
    chk("pre_rst_pend", 32'(Pend), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_pc",   32'(PC), 32'h0020);
    chk("async_rst_pend", 32'(Pend), 0);
    @(negedge CLK); Reset_n = 1'b1;
    m_reset();

    // Wrap on the 8-bit instance.
    drive(0, 1, 0, 16'h00FC);
    chk("wrap_pre", 32'(PC8), 32'hFC);
    drive(0, 0, 0, 16'h0000);
    chk("wrap_pc8",   32'(PC8), 32'h00);
    chk("wrap_plus8", 32'(PC8_Plus), 32'h04);

    // Directed table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].b, tbl[i].s, tbl[i].e, tbl[i].r);
      chk($sformatf("tbl%0d_pc", i),   32'(PC), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d_pend", i), 32'(Pend), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_mis", i),  32'(Misalign), 32'(tbl[i].mis));
      chk($sformatf("tbl%0d_plus", i), 32'(PC_Plus_Step), 32'(W'(tbl[i].pc + 16'd4)));
    end

    // Redirect history sequence.
    do_reset();
    drive(0, 1, 0, 16'h0010);
    drive(0, 1, 0, 16'h0044);
    drive(0, 1, 0, 16'h0088);
    drive(0, 1, 0, 16'h0200);
    Hist_Idx = 2'd0; #1;
`ifdef PC_REDIRECT_HIST_EN
    chk("hist_idx0", 32'(Hist_Data), 32'h0088);
    Hist_Idx = 2'd2; #1;
    chk("hist_idx2", 32'(Hist_Data), 32'h0010);
    drive(0, 1, 0, 16'h0300);
    Hist_Idx = 2'd3; #1;
    chk("hist_wrap_idx3", 32'(Hist_Data), 32'h0010);
    Hist_Idx = 2'd0; #1;
    chk("hist_wrap_idx0", 32'(Hist_Data), 32'h0200);
`else
    chk("hist_off0", 32'(Hist_Data), 0);
    Hist_Idx = 2'd2; #1;
    chk("hist_off2", 32'(Hist_Data), 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic b, s, e;
      logic [W-1:0] r;
      b = ($urandom_range(0, 1) == 1);
      s = ($urandom_range(0, 9) < 4);
      e = ($urandom_range(0, 19) == 0);
      r = W'($urandom);
      if ($urandom_range(0, 1) == 1) r[1:0] = 2'b00;
      Hist_Idx = 2'($urandom);
      drive(b, s, e, r);
      chk("rnd_pc",   32'(PC), 32'(m_pc));
      chk("rnd_pend", 32'(Pend), 32'(m_pend));
      chk("rnd_mis",  32'(Misalign), 32'(m_mis));
      chk("rnd_plus", 32'(PC_Plus_Step), 32'(W'(m_pc + 16'd4)));
      chk("rnd_hist", 32'(Hist_Data), 32'(m_hist_rd(int'(Hist_Idx))));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
